instr_fetch: RTL and testbench

- Fetch stage directly upstream of the branch facility.
- Each unstalled cycle it takes the next instruction address produced by the branch facility and issues an in-order memory read.
- Read data lands in an in-order reservation queue, then goes to instruction identify with address and fault tag.
- Back-pressures the branch facility through a stall output; a flush discards queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/instr_fetch_if.sv | 30 +++
 rtl/fetch_queue.sv | 92 +++++++++
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizes for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_DEPTH = 4;
    localparam int INSTR_W     = 32;
    localparam int ADDR_W      = 64;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
        logic               fault;
        logic               filled;
    } fetch_entry_t;

    // In 32-bit mode the upper address word is forced to zero.
    function automatic logic [ADDR_W-1:0] eff_addr(input logic       mode_32b,
                                                   input logic [ADDR_W-1:0] addr);
        return mode_32b ? {32'h0, addr[31:0]} : addr;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory read channel and instruction-identify channel of the fetch stage.
interface instr_fetch_if;

    logic                         mem_req_valid;
    logic                         mem_req_ready;
    logic [fetch_pkg::ADDR_W-1:0]  mem_req_addr;
    logic                         mem_rsp_valid;
    logic [fetch_pkg::INSTR_W-1:0] mem_rsp_data;
    logic                         mem_rsp_err;
    logic                         instr_valid;
    logic                         instr_ready;
    logic [fetch_pkg::INSTR_W-1:0] instr;
    logic [fetch_pkg::ADDR_W-1:0]  instr_addr;
    logic                         instr_fault;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output instr_valid, instr, instr_addr, instr_fault,
        input  instr_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  instr_valid, instr, instr_addr, instr_fault,
        output instr_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// In-order reservation queue: entries are allocated at the tail, filled
// oldest-unfilled-first by memory responses and popped from the head.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = FETCH_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_alloc,
    input  fetch_entry_t       i_alloc_entry,
    input  logic               i_fill,
    input  logic [INSTR_W-1:0] i_fill_instr,
    input  logic               i_fill_fault,
    input  logic               i_pop,
    output fetch_entry_t       o_head,
    output logic [CNT_W-1:0]   o_count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] fill_idx;
    logic [PTR_W-1:0] scan_idx;
    logic             fill_found;

    // Misaligned entries are born filled, so the fill target is found by
    // scanning from the head rather than by a plain pointer.
    always_comb begin
        fill_idx   = head_q;
        scan_idx   = head_q;
        fill_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (!fill_found && (CNT_W'(i) < count_q) && !mem_q[scan_idx].filled) begin
                fill_idx   = scan_idx;
                fill_found = 1'b1;
            end
        end
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (i_fill) begin
                mem_d[fill_idx].instr  = i_fill_instr;
                mem_d[fill_idx].fault  = i_fill_fault;
                mem_d[fill_idx].filled = 1'b1;
            end
            if (i_alloc) begin
                mem_d[tail_q] = i_alloc_entry;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (i_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(i_alloc) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign o_head  = mem_q[head_q];
    assign o_count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues in-order reads for branch-facility addresses, tracks
// credits and flushed responses, and hands filled entries to identify.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_32b_mode,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_stall,
    input  logic              i_flush,
    instr_fetch_if.master     bus,
    output logic              err_spurious_rsp
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              spurious_q, spurious_d;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      head;
    fetch_entry_t      alloc_entry;
    logic [ADDR_W-1:0] eff;
    logic              aligned, alloc_ok, req_valid, accept, push, pop;
    logic              drop_hit, fill, spurious;

    assign eff     = eff_addr(i_32b_mode, i_fetch_addr);
    assign aligned = (eff[1:0] == 2'b00);

    // Slots owed to flushed responses stay reserved until those responses drain.
    assign alloc_ok  = (({1'b0, count} + {1'b0, drop_cnt_q}) < SUM_W'(DEPTH)) && !i_flush;
    assign req_valid = i_rst_n & aligned & alloc_ok;
    assign accept    = req_valid & bus.mem_req_ready;
    assign push      = aligned ? accept : (i_rst_n & alloc_ok);

    assign drop_hit = bus.mem_rsp_valid & (drop_cnt_q != '0);
    assign fill     = bus.mem_rsp_valid & (drop_cnt_q == '0) & (outstanding_q != '0);
    assign spurious = bus.mem_rsp_valid & (drop_cnt_q == '0) & (outstanding_q == '0);

    assign bus.instr_valid = head.filled & (count != '0);
    assign pop             = bus.instr_valid & bus.instr_ready & !i_flush;

    always_comb begin
        alloc_entry.addr   = eff;
        alloc_entry.instr  = '0;
        alloc_entry.fault  = !aligned;
        alloc_entry.filled = !aligned;
    end

    always_comb begin
        spurious_d    = spurious;
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(fill);
        drop_cnt_d    = drop_cnt_q - CNT_W'(drop_hit);
        if (i_flush) begin
            outstanding_d = '0;
            drop_cnt_d    = drop_cnt_d + outstanding_q - CNT_W'(fill);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            spurious_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            spurious_q    <= spurious_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clear       (i_flush),
        .i_alloc       (push),
        .i_alloc_entry (alloc_entry),
        .i_fill        (fill),
        .i_fill_instr  (bus.mem_rsp_err ? '0 : bus.mem_rsp_data),
        .i_fill_fault  (bus.mem_rsp_err),
        .i_pop         (pop),
        .o_head        (head),
        .o_count       (count)
    );

    assign o_stall          = ~push;
    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = eff;
    assign bus.instr         = head.instr;
    assign bus.instr_addr    = head.addr;
    assign bus.instr_fault   = head.fault;
    assign err_spurious_rsp  = spurious_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch with a queue-based reference model.
module tb_instr_fetch;

    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
        logic        fault;
        logic        filled;
    } ent_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [63:0] addr;
        logic        mode;
    } fa_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode_32b = 1'b0;
    logic [63:0] fetch_addr = '0;
    logic        stall;
    logic        flush = 1'b0;
    logic        spur;

    instr_fetch_if bus ();

    instr_fetch #(.DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_32b_mode       (mode_32b),
        .i_fetch_addr     (fetch_addr),
        .o_stall          (stall),
        .i_flush          (flush),
        .bus              (bus.master),
        .err_spurious_rsp (spur)
    );

    always #5 clk = ~clk;

    ent_t        mq[$];
    pend_t       pq[$];
    fa_t         al[$];
    int          drop_m = 0;
    bit          spur_exp = 1'b0;
    bit          acc_last = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_deliv = 0;
    logic [63:0] pc = '0;

    int rdy_pct = 100, irdy_pct = 100, rsp_pct = 100, err_pct = 0, flush_pm = 0, dly_max = 1;
    bit flush_now = 1'b0, spur_now = 1'b0;

    function automatic logic [63:0] tb_eff(input logic m, input logic [63:0] a);
        return m ? {32'h0, a[31:0]} : a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: entries, drop credits and memory side, updated per edge.
    always @(posedge clk) begin : model
        logic [63:0] e;
        bit aln, aok, psh, acc, do_pop, filled_now;
        int n_unf, first_unf;
        if (!rst_n) begin
            mq.delete(); pq.delete();
            drop_m = 0; spur_exp = 1'b0; acc_last = 1'b1;
        end else begin
            e   = tb_eff(mode_32b, fetch_addr);
            aln = (e[1:0] == 2'b00);
            aok = (mq.size() + drop_m < DEPTH) && !flush;
            psh = aln ? (aok && bus.mem_req_ready) : aok;
            acc = aln && aok && bus.mem_req_ready;
            do_pop = (mq.size() > 0) && mq[0].filled && bus.instr_ready && !flush;
            n_unf = 0; first_unf = -1;
            foreach (mq[i]) if (!mq[i].filled) begin
                if (first_unf < 0) first_unf = i;
                n_unf++;
            end
            spur_exp = 1'b0; filled_now = 1'b0;
            if (bus.mem_rsp_valid) begin
                if (pq.size() > 0) void'(pq.pop_front());
                if (drop_m > 0) drop_m--;
                else if (n_unf > 0) begin
                    mq[first_unf].instr  = bus.mem_rsp_err ? 32'h0 : bus.mem_rsp_data;
                    mq[first_unf].fault  = bus.mem_rsp_err;
                    mq[first_unf].filled = 1'b1;
                    filled_now = 1'b1;
                end else spur_exp = 1'b1;
            end
            if (flush) begin
                drop_m += n_unf - int'(filled_now);
                mq.delete();
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (psh) mq.push_back('{e, 32'h0, !aln, !aln});
            end
            if (acc) pq.push_back('{e, cyc + $urandom_range(1, dly_max)});
            acc_last = psh;
            cyc++;
        end
    end

    // Monitor: compares DUT outputs against the model at mid-cycle.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        bit aln, aok, psh, ev;
        if (rst_n) begin
            e   = tb_eff(mode_32b, fetch_addr);
            aln = (e[1:0] == 2'b00);
            aok = (mq.size() + drop_m < DEPTH) && !flush;
            psh = aln ? (aok && bus.mem_req_ready) : aok;
            chk("stall", 64'(stall), 64'(!psh));
            chk("req_valid", 64'(bus.mem_req_valid), 64'(aln && aok));
            if (aln && aok) chk("req_addr", bus.mem_req_addr, e);
            ev = (mq.size() > 0) && mq[0].filled;
            chk("instr_valid", 64'(bus.instr_valid), 64'(ev));
            if (ev && bus.instr_ready && !flush) begin
                chk("instr", 64'(bus.instr), 64'(mq[0].instr));
                chk("instr_addr", bus.instr_addr, mq[0].addr);
                chk("instr_fault", 64'(bus.instr_fault), 64'(mq[0].fault));
                n_deliv++;
            end
            chk("spurious", 64'(spur), 64'(spur_exp));
        end
    end

    task automatic drive();
        int r;
        if (acc_last) begin
            if (al.size() > 0) begin
                fa_t f;
                f = al.pop_front();
                fetch_addr = f.addr; mode_32b = f.mode;
            end else begin
                r  = $urandom_range(0, 15);
                pc = pc + 64'd4;
                if (r == 0) begin fetch_addr = pc | 64'($urandom_range(1, 3)); mode_32b = 1'b0; end
                else if (r == 1) begin fetch_addr = {$urandom, pc[31:0]}; mode_32b = 1'b1; end
                else begin fetch_addr = pc; mode_32b = 1'b0; end
            end
        end
        bus.mem_req_ready = ($urandom_range(0, 99) < rdy_pct);
        bus.instr_ready   = ($urandom_range(0, 99) < irdy_pct);
        flush = flush_now || ($urandom_range(0, 999) < flush_pm);
        flush_now = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = $urandom;
        bus.mem_rsp_err   = ($urandom_range(0, 99) < err_pct);
        if (pq.size() > 0 && pq[0].due <= cyc && $urandom_range(0, 99) < rsp_pct)
            bus.mem_rsp_valid = 1'b1;
        else if (spur_now && pq.size() == 0) begin
            bus.mem_rsp_valid = 1'b1;
            spur_now = 1'b0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive();
        end
    endtask

    task automatic settle(input int n);
        flush_pm = 0; rdy_pct = 100; irdy_pct = 100; rsp_pct = 100; err_pct = 0; dly_max = 1;
        run(n);
    endtask

    initial begin
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        bus.mem_rsp_err = 1'b0; bus.instr_ready = 1'b0;
        #2;
        chk("rst_instr_valid", 64'(bus.instr_valid), 64'(0));
        chk("rst_req_valid", 64'(bus.mem_req_valid), 64'(0));
        chk("rst_stall", 64'(stall), 64'(1));
        chk("rst_spurious", 64'(spur), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming from 0x0 with single-cycle responses.
        al.push_back('{64'h0, 1'b0}); al.push_back('{64'h4, 1'b0});
        al.push_back('{64'h8, 1'b0}); al.push_back('{64'hC, 1'b0});
        pc = 64'hC;
        settle(12);

        // Fill the queue with identify stalled, then release it.
        irdy_pct = 0; run(8);
        irdy_pct = 100; run(6);

        // Flush with two requests in flight, redirect to 0x100.
        irdy_pct = 0; dly_max = 4; rsp_pct = 0; run(2);
        flush_now = 1'b1; al.push_back('{64'h100, 1'b0}); pc = 64'h100; run(1);
        rsp_pct = 100; irdy_pct = 100; run(12);

        // Flush arriving together with a response.
        irdy_pct = 0; rsp_pct = 0; dly_max = 1; run(3);
        rsp_pct = 100; flush_now = 1'b1; run(1);
        irdy_pct = 100; run(10);

        // Faults: misaligned, bus error, 32-bit mode address truncation.
        al.push_back('{64'h6, 1'b0}); al.push_back('{64'h8, 1'b0});
        al.push_back('{64'hFFFF_0000_0000_0010, 1'b1});
        pc = 64'h10; err_pct = 50; run(12);

        // Randomized traffic.
        rdy_pct = 70; irdy_pct = 60; rsp_pct = 70; err_pct = 10; flush_pm = 20; dly_max = 4;
        run(4000);
        settle(20);

        // Reset with entries queued.
        irdy_pct = 0; run(6);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk("midrst_instr_valid", 64'(bus.instr_valid), 64'(0));
        chk("midrst_stall", 64'(stall), 64'(1));
        @(posedge clk); #1 rst_n = 1'b1;
        drive();

        // Spurious response with nothing outstanding.
        rdy_pct = 0; irdy_pct = 100; run(4);
        spur_now = 1'b1; run(4);
        settle(8);

        chk("deliveries_seen", 64'(n_deliv > 20), 64'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
